// File: rtl/ad9866_spi_responder_if.sv
// AD9866 SPI configuration port bundle: master drives sclk/sdio/sen_n, responder returns sdo and decoded results.
// Pure wiring, no latency; no backpressure, the master paces every frame.
interface ad9866_spi_responder_if;
  logic       sclk;
  logic       sdio;
  logic       sen_n;
  logic       sdo;
  logic       wr_stb;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] rx_gain;
  logic       rx_gain_sel;
  logic       frame_err;

  modport master (
    output sclk, sdio, sen_n,
    input  sdo, wr_stb, wr_addr, wr_data, rx_gain, rx_gain_sel, frame_err
  );

  modport slave (
    input  sclk, sdio, sen_n,
    output sdo, wr_stb, wr_addr, wr_data, rx_gain, rx_gain_sel, frame_err
  );
endinterface

// File: rtl/ad9866_spi_responder.sv
// AD9866 SPI responder: 16-bit frames, shadow regs, RX gain decode; AD9866_SPI_READBACK_EN adds sdo readback.
// Write commits 1 clk after the 16th sclk rise, rx_gain 1 clk later; no backpressure (master-paced).
module ad9866_spi_responder #(
  parameter int         NREGS     = 20,
  parameter logic [4:0] GAIN_ADDR = 5'h0a
) (
  input  logic                 clk,
  input  logic                 reset,
  ad9866_spi_responder_if.slave bus
);
  localparam logic [5:0] NREGS_W = 6'(NREGS);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        sclk_d;
  logic        rise;
  logic        take;
  logic        last;
  logic        abort;
  logic        commit;
  // Only 15 bits are stored: the 16th bit is taken straight from sdio at commit.
  logic [14:0] sr;
  logic [14:0] sr_nxt;
  logic [4:0]  bitcnt;
  logic [7:0]  regs [NREGS];
  logic [4:0]  frame_addr;
  logic [7:0]  frame_data;

  logic        wr_stb_q;
  logic [4:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic [5:0]  rx_gain_q;
  logic        rx_gain_sel_q;
  logic        frame_err_q;

  assign rise       = bus.sclk & ~sclk_d;
  assign frame_addr = sr[11:7];
  assign frame_data = {sr[6:0], bus.sdio};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bus.sen_n) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = HOLD;
               else if (bus.sen_n) state_nxt = IDLE;
      HOLD:    if (bus.sen_n) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The final rise still counts when sen_n lifts on the same clk.
  always_comb begin
    take   = 1'b0;
    sr_nxt = {sr[13:0], bus.sdio};
    case (state)
      IDLE: begin
        take   = rise & ~bus.sen_n;
        sr_nxt = {14'd0, bus.sdio};
      end
      SHIFT:   take = rise & (~bus.sen_n | (bitcnt == 5'd15));
      default: take = 1'b0;
    endcase
    last   = (state == SHIFT) & take & (bitcnt == 5'd15);
    abort  = (state == SHIFT) & bus.sen_n & ~last & (bitcnt != 5'd0);
    commit = last & ~sr[14] & ({1'b0, frame_addr} < NREGS_W);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_d <= 1'b0;
      sr     <= '0;
      bitcnt <= '0;
    end else begin
      sclk_d <= bus.sclk;
      if (take) begin
        sr     <= sr_nxt;
        bitcnt <= (state == IDLE) ? 5'd1 : bitcnt + 5'd1;
      end else if (state == IDLE) begin
        sr     <= '0;
        bitcnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
      wr_stb_q      <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_err_q   <= 1'b0;
      rx_gain_q     <= '0;
      rx_gain_sel_q <= 1'b0;
    end else begin
      wr_stb_q    <= commit;
      frame_err_q <= abort;
      if (commit) begin
        regs[frame_addr] <= frame_data;
        wr_addr_q        <= frame_addr;
        wr_data_q        <= frame_data;
      end
      rx_gain_q     <= regs[GAIN_ADDR][5:0];
      rx_gain_sel_q <= regs[GAIN_ADDR][6];
    end
  end

  assign bus.wr_stb      = wr_stb_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.rx_gain     = rx_gain_q;
  assign bus.rx_gain_sel = rx_gain_sel_q;

`ifdef AD9866_SPI_READBACK_EN
  logic       rd_load;
  logic       rd_active;
  logic [4:0] rd_addr;
  logic [7:0] rd_val;
  logic [7:0] out_sr;

  // At the 8th rise sr[6] is R/W and sr[3:0] plus sdio form the address.
  assign rd_load = (state == SHIFT) & take & (bitcnt == 5'd7) & sr[6];
  assign rd_addr = {sr[3:0], bus.sdio};
  assign rd_val  = ({1'b0, rd_addr} < NREGS_W) ? regs[rd_addr] : 8'h00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_sr    <= '0;
      rd_active <= 1'b0;
    end else if (rd_load) begin
      out_sr    <= rd_val;
      rd_active <= 1'b1;
    end else if (last || state_nxt == IDLE) begin
      out_sr    <= '0;
      rd_active <= 1'b0;
    end else if (take && rd_active) begin
      out_sr <= {out_sr[6:0], 1'b0};
    end
  end

  assign bus.sdo = rd_active & out_sr[7];
`else
  assign bus.sdo = 1'b0;
`endif
endmodule

// File: tb/tb_ad9866_spi_responder.sv
// Randomized SPI master for ad9866_spi_responder with an event-queue reference model and per-cycle compare.
module tb_ad9866_spi_responder;
  localparam int         NREGS = 20;
  localparam logic [4:0] GAIN  = 5'h0a;
`ifdef AD9866_SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct {
    int unsigned cyc;
    bit          wr;
    logic [4:0]  a;
    logic [7:0]  d;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  ad9866_spi_responder_if bus();

  ad9866_spi_responder #(.NREGS(NREGS), .GAIN_ADDR(GAIN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          tests = 0;
  int          fails = 0;
  bit          checking = 1'b0;
  logic [7:0]  mr [32];
  ev_t         evq [$];
  int unsigned rd_from = 32'hffff_ffff;
  int unsigned rd_to   = 32'hffff_ffff;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare: pending commits/errors are applied on the cycle they are due.
  initial begin : cmp
    logic [7:0] greg;
    logic [6:0] gsnap;
    logic [6:0] gexp;
    logic [4:0] wa;
    logic [7:0] wd;
    bit         es;
    bit         ee;
    greg = '0; gsnap = '0; wa = '0; wd = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        greg = '0; gsnap = '0; wa = '0; wd = '0;
        evq.delete();
        if (checking) begin
          chk("rst_wr_stb", 32'(bus.wr_stb), 32'd0);
          chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
          chk("rst_gain", 32'({bus.rx_gain_sel, bus.rx_gain}), 32'd0);
          chk("rst_sdo", 32'(bus.sdo), 32'd0);
        end
      end else begin
        gexp = gsnap;
        es = 1'b0;
        ee = 1'b0;
        while (evq.size() > 0 && evq[0].cyc <= cyc) begin
          if (evq[0].cyc == cyc) begin
            if (evq[0].wr) begin
              es = 1'b1;
              wa = evq[0].a;
              wd = evq[0].d;
              if (evq[0].a == GAIN) greg = evq[0].d;
            end else begin
              ee = 1'b1;
            end
          end
          void'(evq.pop_front());
        end
        gsnap = greg[6:0];
        if (checking) begin
          chk("wr_stb", 32'(bus.wr_stb), 32'(es));
          chk("frame_err", 32'(bus.frame_err), 32'(ee));
          chk("wr_addr", 32'(bus.wr_addr), 32'(wa));
          chk("wr_data", 32'(bus.wr_data), 32'(wd));
          chk("rx_gain", 32'({bus.rx_gain_sel, bus.rx_gain}), 32'(gexp));
          if (!(RB && cyc >= rd_from && cyc < rd_to))
            chk("sdo_quiet", 32'(bus.sdo), 32'd0);
        end
      end
    end
  end

  // One frame as the master sees it; nbits<16 ends the frame early, open_end leaves sen_n low.
  task automatic send_frame(input logic [15:0] w, input int nbits, input bit sim_end,
                            input bit fast, input bit open_end, output logic [7:0] cap);
    int          h;
    int unsigned p;
    logic [4:0]  a;
    logic [7:0]  d;
    logic [7:0]  exp_cap;
    h = $urandom_range(1, 3);
    a = w[12:8];
    d = w[7:0];
    cap = 8'h00;
    exp_cap = (RB && int'(a) < NREGS) ? mr[a] : 8'h00;
    @(negedge clk);
    bus.sen_n = 1'b0;
    bus.sclk  = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      bus.sdio = w[15-b];
      if (!(b == 0 && fast)) repeat (h) @(negedge clk);
      if (b >= 8) cap = {cap[6:0], bus.sdo};
      if (b == 15 && sim_end) bus.sen_n = 1'b1;
      bus.sclk = 1'b1;
      p = cyc + 1;
      if (b == 7 && w[15] && RB) begin
        rd_from = p;
        rd_to   = 32'hffff_ffff;
      end
      if (b == 15) begin
        if (w[15]) rd_to = p;
        else if (int'(a) < NREGS) begin
          evq.push_back('{p, 1'b1, a, d});
          mr[a] = d;
        end
      end
      repeat (h) @(negedge clk);
      bus.sclk = 1'b0;
    end
    if (open_end) return;
    if (nbits == 16 && !sim_end) begin
      repeat ($urandom_range(0, 2)) begin
        repeat (h) @(negedge clk);
        bus.sdio = 1'($urandom);
        bus.sclk = 1'b1;
        repeat (h) @(negedge clk);
        bus.sclk = 1'b0;
      end
    end
    if (nbits == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    if (!sim_end) begin
      bus.sen_n = 1'b1;
      p = cyc + 1;
      if (nbits >= 1 && nbits <= 15) begin
        evq.push_back('{p, 1'b0, 5'd0, 8'd0});
        if (w[15] && nbits >= 8) rd_to = p;
      end
    end
    if (nbits == 16 && w[15]) chk("read_capture", 32'(cap), 32'(exp_cap));
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : drive
    logic [7:0]  cap;
    logic [15:0] init_seq [7];
    logic [15:0] w;
    int          nb;
    init_seq = '{16'h0080, 16'h0721, 16'h084b, 16'h0b20, 16'h0c41, 16'h0d01, 16'h1100};
    foreach (mr[i]) mr[i] = 8'h00;
    bus.sclk  = 1'b0;
    bus.sdio  = 1'b0;
    bus.sen_n = 1'b1;
    checking  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("reset_wr_data", 32'(bus.wr_data), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    send_frame(16'h0a65, 16, 1'b0, 1'b0, 1'b0, cap);
    chk("w0a65_addr", 32'(bus.wr_addr), 32'h0a);
    chk("w0a65_data", 32'(bus.wr_data), 32'h65);
    chk("w0a65_gain", 32'(bus.rx_gain), 32'h25);
    chk("w0a65_sel", 32'(bus.rx_gain_sel), 32'd1);

    send_frame(16'h084b, 16, 1'b0, 1'b0, 1'b0, cap);
    send_frame(16'h8800, 16, 1'b0, 1'b0, 1'b0, cap);
    chk("read_8800", 32'(cap), RB ? 32'h4b : 32'h00);

    foreach (init_seq[i]) begin
      send_frame(init_seq[i], 16, 1'(i % 2), 1'(i == 3), 1'b0, cap);
      w = init_seq[i];
      chk("init_addr", 32'(bus.wr_addr), 32'(w[12:8]));
      chk("init_data", 32'(bus.wr_data), 32'(w[7:0]));
    end
    for (int a = 0; a < 32; a++)
      send_frame({3'b100, 5'(a), 8'h00}, 16, 1'b0, 1'b0, 1'b0, cap);

    send_frame(16'h0a3f, 10, 1'b0, 1'b0, 1'b0, cap);
    chk("short_gain", 32'({bus.rx_gain_sel, bus.rx_gain}), 32'h65);

    send_frame(16'h15aa, 16, 1'b0, 1'b0, 1'b0, cap);
    send_frame(16'h9500, 16, 1'b0, 1'b0, 1'b0, cap);
    chk("read_15", 32'(cap), 32'h00);

    for (int n = 0; n < 150; n++) begin
      w  = 16'($urandom);
      nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : 16;
      send_frame(w, nb, nb == 16 && $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, 1'b0, cap);
    end

    send_frame(16'h0a65, 16, 1'b0, 1'b0, 1'b0, cap);
    send_frame(16'h0a7f, 12, 1'b0, 1'b0, 1'b1, cap);
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("mid_rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("mid_rst_gain", 32'({bus.rx_gain_sel, bus.rx_gain}), 32'd0);
    chk("mid_rst_stb_err", 32'({bus.wr_stb, bus.frame_err, bus.sdo}), 32'd0);
    foreach (mr[i]) mr[i] = 8'h00;
    repeat (2) @(negedge clk);
    bus.sclk  = 1'b0;
    bus.sen_n = 1'b1;
    reset     = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(16'h0a41, 16, 1'b0, 1'b0, 1'b0, cap);
    chk("post_rst_gain", 32'(bus.rx_gain), 32'h01);
    chk("post_rst_sel", 32'(bus.rx_gain_sel), 32'd1);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
